conv2_window_buf: RTL and testbench
===================================

Name: conv2_window_buf

Overview:
- Producer side of the conv2 window interface.
- Consumes the conv1/pool binary feature map as a raster-order stream, one pixel per beat; each pixel carries NUM_CH one-bit channels.
- Buffers two image rows plus a 3x3 register window.
- Emits each valid (unpadded) 3x3xNUM_CH window as a single flat word with a one-cycle valid strobe, directly driving the conv2 popcount/threshold stage (valid_in_buf, pixel_windows).

Parameters:
- IMG_W, 13, feature-map width in pixels (>=3).
- IMG_H, 13, feature-map height in pixels (>=3).
- NUM_CH, 8, input channels per pixel; window width is 9*NUM_CH (72 by default).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  pixel_in valid this cycle; no backpressure; gaps allowed at any time.
- pixel_in  input  NUM_CH  binary pixel, bit ch = channel ch.
- pixel_windows  output  9*NUM_CH  window; bit index ch*9+k, k=ro*3+co; ro 0=top row, co 0=left column.
- valid_in_buf  output  1  pixel_windows valid; one-cycle pulse per window.
- frame_done  output  1  pulses together with valid_in_buf for the last window of a frame.

Behaviour:
- Reset is asynchronous on rst_n low and clears:
  - pixel_windows = 0, valid_in_buf = 0, frame_done = 0.
  - Row/column counters = 0.
  - Window registers = 0.
- Line-buffer contents are don't-care; they are never observed before being written in the current frame.
- Counters:
  - col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the pixel accepted this beat.
  - Width is clog2 of each dimension.
  - Counters advance only on valid_in=1.
  - col wraps to 0 and row increments at col=IMG_W-1.
  - At row=IMG_H-1, col=IMG_W-1, both wrap to 0; the next beat is pixel (0,0) of a new frame, with no idle cycle required.
- Storage:
  - lb0 holds row r-1 and lb1 holds row r-2, each IMG_W x NUM_CH, indexed by col.
  - Window: 3 columns x 3 rows x NUM_CH registers.
- Accepted beat at (r,c), all updates in the same clock edge:
  - Window shifts left one column; new right column = {top: lb1[c], mid: lb0[c], bottom: pixel_in}.
  - lb1[c] <= lb0[c]; lb0[c] <= pixel_in.
- Output:
  - valid_in_buf is registered and asserted in the cycle after an accepted beat with r>=2 and c>=2.
  - pixel_windows then holds rows r-2..r, cols c-2..c.
  - Latency is 1 cycle from the bottom-right pixel beat.
- valid_in_buf is 0 in all other cycles, including valid_in=0 cycles and beats with r<2 or c<2.
- pixel_windows holds its last value when valid_in_buf=0; the consumer must not rely on it.
- Windows never span a row wrap. Stale columns from the previous row are shifted out by c=2 and never emitted.
- Windows per frame: (IMG_W-2)*(IMG_H-2), 121 by default.
- First window appears 1 cycle after beat number 2*IMG_W+3 (beat 29 by default, 1-based).
- frame_done = 1 only in the cycle where valid_in_buf reports window (IMG_H-1, IMG_W-1).
- Stalls: any pattern of valid_in gaps must produce the same window sequence as a gap-free stream; only timing changes.
- Reset mid-frame: state returns to the reset state. The next accepted beat is treated as pixel (0,0), and no window combining pre-reset data is emitted.
- No combinational path from inputs to outputs.

Test Plan:
- All-ones image (pixel_in = 8'hFF each beat, IMG_W = IMG_H = 13, gap-free):
  - first valid_in_buf 1 cycle after beat 29;
  - every window = 72'hFF_FFFF_FFFF_FFFF_FFFF;
  - exactly 121 pulses;
  - frame_done exactly once, on the 121st pulse.
- Single hot pixel (all channels 1 at (5,5), zero elsewhere):
  - window ending at (7,7): only bits ch*9+0 set, i.e. 0x1 per 9-bit channel slice;
  - window ending at (5,5): only bits ch*9+8 set;
  - window ending at (6,6): only bits ch*9+4 set;
  - all windows not covering (5,5) are zero.
- Ramp pattern (pixel_in = (r*13+c) mod 256, random 0-3 idle cycles between beats):
  - window sequence bit-exact to a software 3x3 extraction model;
  - 121 windows;
  - valid_in_buf never high for 2 consecutive cycles unless valid_in was high in both preceding cycles.
- Two back-to-back frames with no gap:
  - second frame's first window appears exactly 29 beats after the first frame's last beat;
  - its contents contain no pixels from frame 1.
- Reset asserted mid-frame at row 6, col 4:
  - outputs go 0 asynchronously;
  - after release, a full new frame yields the all-ones-test behaviour (first window after beat 29, 121 windows).
- Row-boundary check on the ramp image:
  - no valid_in_buf after beats at c=0 or c=1 of any row;
  - window ending at (3,2) = rows 1..3, cols 0..2 of the ramp.

Source files
------------

// File: rtl/conv2_window_buf.sv
// conv2_window_buf: two-row line buffer plus 3x3 register window emitting flat binary windows
module conv2_window_buf #(
  parameter int IMG_W  = 13,
  parameter int IMG_H  = 13,
  parameter int NUM_CH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [NUM_CH-1:0]     pixel_in,
  output logic [9*NUM_CH-1:0]   pixel_windows,
  output logic                  valid_in_buf,
  output logic                  frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [NUM_CH-1:0] lb0 [IMG_W];
  logic [NUM_CH-1:0] lb1 [IMG_W];
  logic [NUM_CH-1:0] win [3][3];
  logic [NUM_CH-1:0] nwin [3][3];
  logic [9*NUM_CH-1:0] flat;
  logic col_end, row_end, emit;
  assign col_end = col == CW'(IMG_W - 1);
  assign row_end = row == RW'(IMG_H - 1);
  assign emit    = valid_in && col >= CW'(2) && row >= RW'(2);
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nwin[i][0] = win[i][1];
      nwin[i][1] = win[i][2];
    end
    nwin[0][2] = lb1[col];
    nwin[1][2] = lb0[col];
    nwin[2][2] = pixel_in;
    flat = '0;
    for (int h = 0; h < NUM_CH; h++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          flat[h*9 + i*3 + j] = nwin[i][j][h];
  end
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pixel_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      pixel_windows <= '0;
      valid_in_buf  <= 1'b0;
      frame_done    <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      valid_in_buf <= emit;
      frame_done   <= emit && col_end && row_end;
      if (valid_in) begin
        col <= col_end ? '0 : col + 1'b1;
        row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
        win <= nwin;
      end
      if (emit) pixel_windows <= flat;
    end
  end
endmodule

// File: tb/tb_conv2_window_buf.sv
// tb_conv2_window_buf: directed checks of window extraction, stalls, frame chaining and reset
module tb_conv2_window_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic [71:0] pixel_windows;
  logic        valid_in_buf;
  logic        frame_done;
  int checks = 0;
  int errors = 0;
  logic [71:0] got [13][13];
  conv2_window_buf dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pixel_in(pixel_in),
    .pixel_windows(pixel_windows), .valid_in_buf(valid_in_buf), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] px(input int mode, input int r, input int c);
    if (mode == 0) return 8'hFF;
    if (mode == 1) return (r == 5 && c == 5) ? 8'hFF : 8'h00;
    return 8'((r*13 + c) % 256);
  endfunction
  function automatic logic [71:0] exp_win(input int mode, input int r, input int c);
    logic [71:0] w;
    logic [7:0]  p;
    w = '0;
    for (int ro = 0; ro < 3; ro++)
      for (int co = 0; co < 3; co++) begin
        p = px(mode, r - 2 + ro, c - 2 + co);
        for (int ch = 0; ch < 8; ch++) w[ch*9 + ro*3 + co] = p[ch];
      end
    return w;
  endfunction
  task automatic run_frame(input int mode, input int maxgap, input int nbeats,
                           output int pulses, output int fdones, output int first);
    int r, c, g;
    logic exp_v;
    pulses = 0; fdones = 0; first = 0;
    for (int i = 0; i < 13; i++) for (int j = 0; j < 13; j++) got[i][j] = 'x;
    for (int n = 0; n < nbeats; n++) begin
      r = n / 13; c = n % 13;
      g = maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
      for (int k = 0; k < g; k++) begin
        @(posedge clk); #1;
        checks++;
        if (valid_in_buf !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL idle_quiet beat %0d valid=%b done=%b required 0/0", n, valid_in_buf, frame_done);
        end
      end
      valid_in = 1'b1; pixel_in = px(mode, r, c);
      @(posedge clk); #1;
      valid_in = 1'b0;
      exp_v = r >= 2 && c >= 2;
      checks++;
      if (valid_in_buf !== exp_v) begin
        errors++;
        $display("FAIL valid (%0d,%0d) got %b required %b", r, c, valid_in_buf, exp_v);
      end
      checks++;
      if (frame_done !== (r == 12 && c == 12)) begin
        errors++;
        $display("FAIL frame_done (%0d,%0d) got %b required %b", r, c, frame_done, r == 12 && c == 12);
      end
      if (valid_in_buf === 1'b1) begin
        pulses++;
        got[r][c] = pixel_windows;
        if (first == 0) first = n + 1;
      end
      if (frame_done === 1'b1) fdones++;
      if (exp_v) begin
        checks++;
        if (pixel_windows !== exp_win(mode, r, c)) begin
          errors++;
          $display("FAIL window (%0d,%0d) got %h required %h", r, c, pixel_windows, exp_win(mode, r, c));
        end
      end
    end
  endtask
  task automatic check_frame(input string name, input int pulses, input int fdones, input int first);
    checks++;
    if (pulses !== 121) begin errors++; $display("FAIL %s_pulses got %0d required 121", name, pulses); end
    checks++;
    if (fdones !== 1) begin errors++; $display("FAIL %s_frame_done_count got %0d required 1", name, fdones); end
    checks++;
    if (first !== 29) begin errors++; $display("FAIL %s_first_beat got %0d required 29", name, first); end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pixel_windows !== '0 || valid_in_buf !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %h/%b/%b required 0/0/0", pixel_windows, valid_in_buf, frame_done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_all_ones();
    int p, f, b;
    run_frame(0, 0, 169, p, f, b);
    check_frame("ones", p, f, b);
    checks++;
    if (pixel_windows !== 72'hFF_FFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL ones_last_window got %h required ff_ffff_ffff_ffff_ffff", pixel_windows);
    end
  endtask
  task automatic test_hot_pixel();
    int p, f, b;
    logic [71:0] expv;
    run_frame(1, 0, 169, p, f, b);
    checks++;
    if (got[7][7] !== {8{9'h001}}) begin errors++; $display("FAIL hot_77 got %h required %h", got[7][7], {8{9'h001}}); end
    checks++;
    if (got[5][5] !== {8{9'h100}}) begin errors++; $display("FAIL hot_55 got %h required %h", got[5][5], {8{9'h100}}); end
    checks++;
    if (got[6][6] !== {8{9'h010}}) begin errors++; $display("FAIL hot_66 got %h required %h", got[6][6], {8{9'h010}}); end
    for (int r = 2; r < 13; r++)
      for (int c = 2; c < 13; c++)
        if (!(r >= 5 && r <= 7 && c >= 5 && c <= 7)) begin
          checks++;
          if (got[r][c] !== '0) begin errors++; $display("FAIL hot_zero (%0d,%0d) got %h required 0", r, c, got[r][c]); end
        end
  endtask
  task automatic test_ramp_gaps();
    int p, f, b;
    int vals [9] = '{13, 14, 15, 26, 27, 28, 39, 40, 41};
    logic [71:0] expv;
    logic [7:0] v;
    run_frame(2, 3, 169, p, f, b);
    check_frame("ramp", p, f, b);
    expv = '0;
    for (int k = 0; k < 9; k++) begin
      v = 8'(vals[k]);
      for (int ch = 0; ch < 8; ch++) expv[ch*9 + k] = v[ch];
    end
    checks++;
    if (got[3][2] !== expv) begin errors++; $display("FAIL ramp_window_32 got %h required %h", got[3][2], expv); end
  endtask
  task automatic test_back_to_back();
    int p, f, b;
    run_frame(0, 0, 169, p, f, b);
    check_frame("b2b_f1", p, f, b);
    run_frame(2, 0, 169, p, f, b);
    check_frame("b2b_f2", p, f, b);
  endtask
  task automatic test_mid_reset();
    int p, f, b;
    run_frame(2, 0, 6*13 + 4, p, f, b);
    checks++;
    if (valid_in_buf !== 1'b1 || pixel_windows === '0) begin
      errors++;
      $display("FAIL pre_reset_active got %b/%h required 1/nonzero", valid_in_buf, pixel_windows);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pixel_windows !== '0 || valid_in_buf !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %h/%b/%b required 0/0/0", pixel_windows, valid_in_buf, frame_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(0, 0, 169, p, f, b);
    check_frame("post_reset", p, f, b);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_all_ones();
    test_hot_pixel();
    test_ramp_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
